// File: rtl/pts_cmd_parser_if.sv
// Host byte stream in, controller strobes and frame status out, for pts_cmd_parser.
interface pts_cmd_parser_if;
  logic [7:0]  iRxData;
  logic        iRxValid;
  logic        oSET_INDEX_FLAG;
  logic [7:0]  oSET_INDEX;
  logic        oSET_CODE_FLAG;
  logic [31:0] oSET_CODE;
  logic        oBusy;
  logic        oFrameOk;
  logic        oFrameErr;
  logic [7:0]  oErrCount;

  modport slave (
    input  iRxData, iRxValid,
    output oSET_INDEX_FLAG, oSET_INDEX, oSET_CODE_FLAG, oSET_CODE,
           oBusy, oFrameOk, oFrameErr, oErrCount
  );

  modport master (
    output iRxData, iRxValid,
    input  oSET_INDEX_FLAG, oSET_INDEX, oSET_CODE_FLAG, oSET_CODE,
           oBusy, oFrameOk, oFrameErr, oErrCount
  );
endinterface

// File: rtl/pts_cmd_parser.sv
// Parses framed host bytes (HEADER, CMD, payload, XOR checksum) into setup/pulse/hold
// SET_INDEX / SET_CODE strobes for the PTS controller, with frame status and error count.
module pts_cmd_parser #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned TIMEOUT = 50000
) (
  input logic iClk,
  input logic iRst,
  pts_cmd_parser_if.slave bus
);

  localparam int unsigned TW  = $clog2(TIMEOUT);
  localparam int unsigned ECW = $clog2(2 * PULSE_W + 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [ECW-1:0] PW_C      = ECW'(PULSE_W);
  localparam logic [ECW-1:0] EMIT_LAST = ECW'(2 * PULSE_W);
  localparam logic [7:0] CMD_IDX  = 8'h01;
  localparam logic [7:0] CMD_CODE = 8'h02;
  localparam logic [7:0] CMD_WR   = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_PAYLOAD, S_CHK, S_EMIT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [39:0]     pay_q, pay_d;
  logic [7:0]      chk_q, chk_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [ECW-1:0]  emit_cnt_q, emit_cnt_d;
  logic            emit_code_q, emit_code_d;
  logic [7:0]      set_index_q, set_index_d;
  logic [31:0]     set_code_q, set_code_d;
  logic            idx_flag_q, idx_flag_d;
  logic            code_flag_q, code_flag_d;
  logic            busy_q, busy_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            in_pulse;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    pay_d       = pay_q;
    chk_d       = chk_q;
    timer_d     = '0;
    emit_cnt_d  = emit_cnt_q;
    emit_code_d = emit_code_q;
    set_index_d = set_index_q;
    set_code_d  = set_code_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    in_pulse    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.iRxValid && bus.iRxData == HEADER) state_d = S_CMD;
      end
      S_CMD, S_PAYLOAD, S_CHK: begin
        if (!bus.iRxValid) begin
          if (timer_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end else if (state_q == S_CMD) begin
          if (bus.iRxData == CMD_IDX || bus.iRxData == CMD_CODE || bus.iRxData == CMD_WR) begin
            cmd_d   = bus.iRxData;
            chk_d   = bus.iRxData;
            cnt_d   = (bus.iRxData == CMD_WR) ? 3'd5 : (bus.iRxData == CMD_CODE) ? 3'd4 : 3'd1;
            state_d = S_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (state_q == S_PAYLOAD) begin
          // payload shifts MSB-first into one buffer: index lands in [7:0] or [39:32]
          pay_d = {pay_q[31:0], bus.iRxData};
          chk_d = chk_q ^ bus.iRxData;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == 3'd1) state_d = S_CHK;
        end else if (bus.iRxData == chk_q) begin
          state_d     = S_EMIT;
          emit_cnt_d  = '0;
          emit_code_d = (cmd_q == CMD_CODE);
          if (cmd_q == CMD_CODE) set_code_d  = pay_q[31:0];
          else                   set_index_d = (cmd_q == CMD_IDX) ? pay_q[7:0] : pay_q[39:32];
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (bus.iRxValid) err_d = 1'b1;
        if (emit_cnt_q == EMIT_LAST) begin
          if (!emit_code_q && cmd_q == CMD_WR) begin
            emit_code_d = 1'b1;
            emit_cnt_d  = '0;
            set_code_d  = pay_q[31:0];
          end else begin
            state_d = S_IDLE;
            ok_d    = 1'b1;
          end
        end else begin
          emit_cnt_d = emit_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_pulse    = (state_d == S_EMIT) && (emit_cnt_d != '0) && (emit_cnt_d <= PW_C);
    idx_flag_d  = in_pulse && !emit_code_d;
    code_flag_d = in_pulse && emit_code_d;
    busy_d      = (state_d != S_IDLE);
    err_cnt_d   = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 1'b1 : err_cnt_q;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      pay_q       <= '0;
      chk_q       <= '0;
      timer_q     <= '0;
      emit_cnt_q  <= '0;
      emit_code_q <= 1'b0;
      set_index_q <= '0;
      set_code_q  <= '0;
      idx_flag_q  <= 1'b0;
      code_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      pay_q       <= pay_d;
      chk_q       <= chk_d;
      timer_q     <= timer_d;
      emit_cnt_q  <= emit_cnt_d;
      emit_code_q <= emit_code_d;
      set_index_q <= set_index_d;
      set_code_q  <= set_code_d;
      idx_flag_q  <= idx_flag_d;
      code_flag_q <= code_flag_d;
      busy_q      <= busy_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.oSET_INDEX_FLAG = idx_flag_q;
  assign bus.oSET_INDEX      = set_index_q;
  assign bus.oSET_CODE_FLAG  = code_flag_q;
  assign bus.oSET_CODE       = set_code_q;
  assign bus.oBusy           = busy_q;
  assign bus.oFrameOk        = ok_q;
  assign bus.oFrameErr       = err_q;
  assign bus.oErrCount       = err_cnt_q;

endmodule
